// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming KxK convolution engine.
package conv_pkg;

  localparam int K_MIN = 2;
  localparam int K_MAX = 5;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Accumulator width: full signed product plus growth for K*K terms.
  function automatic int acc_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_kxk_stream_mac_tree.sv
// K*K signed multipliers, product register and registered adder with output stage.
// Optional CONV_RELU_EN clamps negative sums to zero at the output register.
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_weight [K*K],
  input  logic signed [DATA_W-1:0] i_win    [K*K],
  output logic                     o_busy,
  output logic                     o_valid,
  output logic                     o_last,
  output logic        [ACC_W-1:0]  o_data
);

  localparam int NTAP  = K * K;
  localparam int PW    = 2 * DATA_W;

  logic signed [PW-1:0]    w_prod [NTAP];
  logic signed [ACC_W-1:0] r_prod [NTAP];
  logic                    r_pvalid;
  logic                    r_plast;
  logic signed [ACC_W-1:0] w_sum;
  logic        [ACC_W-1:0] w_out;
  logic        [ACC_W-1:0] r_data;
  logic                    r_valid;
  logic                    r_last;

  for (genvar i = 0; i < NTAP; i++) begin : g_mul
    assign w_prod[i] = i_weight[i] * i_win[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the product array is small and lives in flops, so it is reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) r_prod[i] <= '0;
      r_pvalid <= 1'b0;
      r_plast  <= 1'b0;
    end else if (i_en) begin
      for (int i = 0; i < NTAP; i++)
        r_prod[i] <= {{(ACC_W - PW){w_prod[i][PW-1]}}, w_prod[i]};
      r_pvalid <= i_valid;
      r_plast  <= i_last;
    end
  end

  // NOTE: default assignment first so no path through the block leaves w_sum unassigned (no latch).
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NTAP; i++) w_sum = w_sum + r_prod[i];
  end

`ifdef CONV_RELU_EN
  assign w_out = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_out = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_en) begin
      r_data  <= w_out;
      r_valid <= r_pvalid;
      r_last  <= r_plast;
    end
  end

  assign o_busy  = r_pvalid | r_valid;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution: weight-load FSM, raster counters, line buffers and window array.
// Build option: CONV_RELU_EN (clamps negative results to zero, same latency).
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int K          = 3,
  parameter  int IMG_WIDTH  = 8,
  parameter  int IMG_HEIGHT = 8,
  localparam int ACC_W      = acc_w(DATA_W, K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_load_valid,
  input  logic [DATA_W-1:0] w_load_data,
  output logic              w_load_err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_last,
  output logic              weights_loaded
);

  localparam int NTAP  = K * K;
  localparam int IDX_W = $clog2(NTAP);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);

  if (K < K_MIN || K > K_MAX) begin : g_k_range
    $error("conv_kxk_stream: K out of legal range");
  end

  state_t                     r_state, w_state_nxt;
  logic        [IDX_W-1:0]    r_widx, w_widx_nxt;
  logic                       w_wr_en;
  logic        [IDX_W-1:0]    w_wr_idx;
  logic                       w_err_nxt;
  logic                       r_err;
  logic signed [DATA_W-1:0]   r_weight [NTAP];
  logic signed [DATA_W-1:0]   r_lb     [K-1][IMG_WIDTH];
  logic signed [DATA_W-1:0]   r_win    [K][K];
  logic signed [DATA_W-1:0]   w_win_flat [NTAP];
  logic        [CW-1:0]       r_col;
  logic        [RW-1:0]       r_row;
  logic                       r_win_valid;
  logic                       r_win_last;
  logic                       w_adv;
  logic                       w_accept;
  logic                       w_mac_busy;
  logic                       w_reload_ok;

  assign w_adv    = !m_valid || m_ready;
  assign s_ready  = (r_state == STREAM) && w_adv;
  assign w_accept = s_valid && s_ready;

  // A reload must not coincide with a pixel accept, or that pixel would straddle two weight sets.
  assign w_reload_ok = (r_col == '0) && (r_row == '0) && !r_win_valid && !w_mac_busy && !w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_widx_nxt  = r_widx;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_widx;
    w_err_nxt   = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_load_valid) begin
          w_wr_en = 1'b1;
          if (r_widx == IDX_W'(NTAP - 1)) begin
            w_state_nxt = STREAM;
            w_widx_nxt  = '0;
          end else begin
            w_widx_nxt = r_widx + 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_load_valid) begin
          if (w_reload_ok) begin
            w_state_nxt = LOAD;
            w_wr_en     = 1'b1;
            w_wr_idx    = '0;
            w_widx_nxt  = IDX_W'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
      r_widx  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NTAP; i++) r_weight[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_widx  <= w_widx_nxt;
      r_err   <= w_err_nxt;
      if (w_wr_en) r_weight[w_wr_idx] <= w_load_data;
    end
  end

  // Line buffer j's tail holds the pixel j+1 rows above the incoming one, same column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < K - 1; j++)
        for (int i = 0; i < IMG_WIDTH; i++) r_lb[j][i] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) r_win[r][c] <= '0;
    end else if (w_accept) begin
      for (int j = 0; j < K - 1; j++)
        for (int i = IMG_WIDTH - 1; i > 0; i--) r_lb[j][i] <= r_lb[j][i-1];
      r_lb[0][0] <= s_data;
      for (int j = 1; j < K - 1; j++) r_lb[j][0] <= r_lb[j-1][IMG_WIDTH-1];
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_win[r][c+1];
      for (int r = 0; r < K - 1; r++) r_win[r][K-1] <= r_lb[K-2-r][IMG_WIDTH-1];
      r_win[K-1][K-1] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_col == CW'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_adv) begin
        r_win_valid <= w_accept && (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));
        r_win_last  <= w_accept && (r_row == RW'(IMG_HEIGHT - 1)) && (r_col == CW'(IMG_WIDTH - 1));
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign w_win_flat[r*K + c] = r_win[r][c];
    end
  end

  conv_mac_tree #(
    .DATA_W (DATA_W),
    .K      (K),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_adv),
    .i_valid  (r_win_valid),
    .i_last   (r_win_last),
    .i_weight (r_weight),
    .i_win    (w_win_flat),
    .o_busy   (w_mac_busy),
    .o_valid  (m_valid),
    .o_last   (m_last),
    .o_data   (m_data)
  );

  assign w_load_err     = r_err;
  assign weights_loaded = (r_state == STREAM);

endmodule
